primitive_port_arbiter: RTL and testbench

- Shares the single BVH primitive/node fetch port (start_primitive, node_index -> p[], node, leaf[]) between NUM_REQ traversal requesters (shadowing units, reflection/refraction units).
- Round-robin grant with a time-slice quantum. The owner holds the port for consecutive cycles, so one traversal advances without re-arbitration each step.
- Returns a per-requester response-valid aligned to the memory read latency.
- Sits between the shading-stage units and the primitive/node memories in RayCore.

---
 rtl/primitive_port_arbiter_pkg.sv | 21 ++
 rtl/primitive_port_arbiter_rr_pick.sv | 38 +++
 rtl/primitive_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_primitive_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/primitive_port_arbiter_pkg.sv
// Shared types for the primitive/node fetch-port arbiter.
//   ArbiterState : arbiter FSM state encoding.
// Falls back to default BVH index widths when the RayCore headers are not in
// the compilation unit.

`ifndef BVH_PRIMITIVE_INDEX_WIDTH
`define BVH_PRIMITIVE_INDEX_WIDTH 16
`endif
`ifndef BVH_NODE_INDEX_WIDTH
`define BVH_NODE_INDEX_WIDTH 16
`endif

package primitive_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_Idle   = 2'd0,
      ARB_Own    = 2'd1,
      ARB_Switch = 2'd2
   } ArbiterState;

endpackage

// File: rtl/primitive_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
//   req    : request vector
//   ptr    : index searched first; search wraps upward from here
//   any    : at least one request present
//   onehot : winning request as a one-hot vector (zero when none)
//   idx    : winning request index (zero when none)

module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          any,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx
);

   logic          found;
   logic [PW-1:0] cand;

   always_comb begin
      any    = |req;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/primitive_port_arbiter.sv
// Round-robin, time-sliced arbiter sharing the BVH primitive/node fetch port
// between NUM_REQ traversal requesters.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid            : per-requester port request, held for a traversal
//   req_start_primitive  : packed per-requester primitive start index
//   req_end_primitive    : packed per-requester primitive end index
//   req_node_index       : packed per-requester node index
//   gnt                  : registered one-hot grant
//   rsp_valid            : gnt delayed by MEM_LATENCY, tags returning data
//   mem_*                : owner's indices, zero when nothing is granted
//   busy                 : owner present or response still in flight
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_Idle   | no owner; pick from rr_ptr when any request is present
// ARB_Own    | gnt held by one requester; time slice counting down
// ARB_Switch | one gnt=0 bubble after preemption, then pick as in Idle

module primitive_port_arbiter
   import primitive_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int PRIM_W      = `BVH_PRIMITIVE_INDEX_WIDTH,
   parameter int NODE_W      = `BVH_NODE_INDEX_WIDTH,
   parameter int QUANTUM     = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*PRIM_W-1:0] req_start_primitive,
   input  logic [NUM_REQ*PRIM_W-1:0] req_end_primitive,
   input  logic [NUM_REQ*NODE_W-1:0] req_node_index,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [PRIM_W-1:0]         mem_start_primitive,
   output logic [PRIM_W-1:0]         mem_end_primitive,
   output logic [NODE_W-1:0]         mem_node_index,
   output logic                      busy
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(QUANTUM + 1);

   ArbiterState        state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   // Remaining cycles of the slice; reaching zero means the quantum is used up
   // and the counter parks there until a competitor shows up.
   logic [CW-1:0]      slice_left_q, slice_left_d;

   logic               pick_any;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [PW-1:0]      pick_idx;
   logic [PW-1:0]      owner_idx;
   logic [PW-1:0]      owner_next;
   logic               owner_req;
   logic               others_req;
   logic               slice_done;
   logic               pipe_any;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_pick (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) owner_idx = PW'(i);
      end
   end

   assign owner_next = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
   assign owner_req  = |(req_valid & gnt_q);
   assign others_req = |(req_valid & ~gnt_q);
   assign slice_done = (slice_left_q == '0);

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rr_ptr_d     = rr_ptr_q;
      slice_left_d = slice_left_q;
      case (state_q)
         ARB_Idle, ARB_Switch: begin
            if (pick_any) begin
               gnt_d        = pick_onehot;
               slice_left_d = CW'(QUANTUM - 1);
               state_d      = ARB_Own;
            end else begin
               gnt_d   = '0;
               state_d = ARB_Idle;
            end
         end
         ARB_Own: begin
            if (!slice_done) slice_left_d = slice_left_q - CW'(1);
            // Release wins over preemption; both clear gnt and advance rr_ptr.
            if (!owner_req) begin
               gnt_d    = '0;
               rr_ptr_d = owner_next;
               state_d  = ARB_Idle;
            end else if (slice_done && others_req) begin
               gnt_d    = '0;
               rr_ptr_d = owner_next;
               state_d  = ARB_Switch;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ARB_Idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ARB_Idle;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         slice_left_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         slice_left_q <= slice_left_d;
      end
   end

   generate
      if (MEM_LATENCY == 0) begin : g_no_delay
         assign rsp_valid = gnt_q;
         assign pipe_any  = 1'b0;
      end else begin : g_delay
         logic [MEM_LATENCY-1:0][NUM_REQ-1:0] rsp_pipe_q, rsp_pipe_d;

         always_comb begin
            rsp_pipe_d    = '0;
            rsp_pipe_d[0] = gnt_q;
            for (int k = 1; k < MEM_LATENCY; k++) begin
               rsp_pipe_d[k] = rsp_pipe_q[k-1];
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) rsp_pipe_q <= '0;
            else         rsp_pipe_q <= rsp_pipe_d;
         end

         assign rsp_valid = rsp_pipe_q[MEM_LATENCY-1];
         assign pipe_any  = |rsp_pipe_q;
      end
   endgenerate

   // AND-OR mux keyed on the grant register, so an idle port drives zeros.
   always_comb begin
      mem_start_primitive = '0;
      mem_end_primitive   = '0;
      mem_node_index      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            mem_start_primitive = mem_start_primitive | req_start_primitive[i*PRIM_W +: PRIM_W];
            mem_end_primitive   = mem_end_primitive   | req_end_primitive[i*PRIM_W +: PRIM_W];
            mem_node_index      = mem_node_index      | req_node_index[i*NODE_W +: NODE_W];
         end
      end
   end

   assign gnt  = gnt_q;
   assign busy = (|gnt_q) | pipe_any;

`ifndef SYNTHESIS
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt_q));
   a_rsp_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(rsp_valid));
   a_gnt_had_req: assert property (@(posedge clk) disable iff (!resetn)
      (gnt_q & ~$past(req_valid)) == '0);
`endif

endmodule

// File: tb/tb_primitive_port_arbiter.sv
module tb_primitive_port_arbiter;

   localparam int N  = 4;
   localparam int PW = 16;
   localparam int NW = 12;
   localparam int Q  = 64;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*PW-1:0] req_start = '0;
   logic [N*PW-1:0] req_end = '0;
   logic [N*NW-1:0] req_node = '0;

   logic [N-1:0]  gnt1, rsp1, gnt3, rsp3;
   logic [PW-1:0] ms1, me1, ms3, me3;
   logic [NW-1:0] mn1, mn3;
   logic          busy1, busy3;

   always #5 clk = ~clk;

   primitive_port_arbiter #(
      .NUM_REQ(N), .PRIM_W(PW), .NODE_W(NW), .QUANTUM(Q), .MEM_LATENCY(1)
   ) dut1 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid),
      .req_start_primitive(req_start), .req_end_primitive(req_end),
      .req_node_index(req_node), .gnt(gnt1), .rsp_valid(rsp1),
      .mem_start_primitive(ms1), .mem_end_primitive(me1),
      .mem_node_index(mn1), .busy(busy1)
   );

   primitive_port_arbiter #(
      .NUM_REQ(N), .PRIM_W(PW), .NODE_W(NW), .QUANTUM(Q), .MEM_LATENCY(3)
   ) dut3 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid),
      .req_start_primitive(req_start), .req_end_primitive(req_end),
      .req_node_index(req_node), .gnt(gnt3), .rsp_valid(rsp3),
      .mem_start_primitive(ms3), .mem_end_primitive(me3),
      .mem_node_index(mn3), .busy(busy3)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: who owns the port, how many cycles it has shown gnt,
   // where the next search starts, and a history of past grants.
   int           m_owner;
   int           m_held;
   int           m_ptr;
   logic [N-1:0] m_gnt;
   logic [N-1:0] m_hist [3];

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_gnt   = '0;
      for (int k = 0; k < 3; k++) m_hist[k] = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] others;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = m_gnt;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && req_valid[c]) begin
               m_owner = c;
               m_held  = 1;
            end
         end
      end else begin
         others = req_valid;
         others[m_owner] = 1'b0;
         if (!req_valid[m_owner] || (m_held >= Q && others != '0)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
      m_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endtask

   logic [N-1:0]  last_gnt, last_rsp1, last_rsp3;
   logic          last_busy1;
   logic [PW-1:0] last_ms1, last_start0;

   task automatic check_all();
      logic [PW-1:0] es, ee;
      logic [NW-1:0] en;
      es = '0; ee = '0; en = '0;
      if (m_owner >= 0) begin
         es = req_start[m_owner*PW +: PW];
         ee = req_end[m_owner*PW +: PW];
         en = req_node[m_owner*NW +: NW];
      end
      chk("gnt_l1", gnt1, m_gnt);
      chk("gnt_l3", gnt3, m_gnt);
      chk("rsp_l1", rsp1, m_hist[0]);
      chk("rsp_l3", rsp3, m_hist[2]);
      chk("busy_l1", busy1, (m_gnt | m_hist[0]) != '0);
      chk("busy_l3", busy3, (m_gnt | m_hist[0] | m_hist[1] | m_hist[2]) != '0);
      chk("mem_start", ms1, es);
      chk("mem_end", me1, ee);
      chk("mem_node", mn1, en);
      chk("mem_start_l3", ms3, es);
   endtask

   task automatic cycle(input logic [N-1:0] req);
      req_valid = req;
      for (int i = 0; i < N; i++) begin
         req_start[i*PW +: PW] = PW'($urandom);
         req_end[i*PW +: PW]   = PW'($urandom);
         req_node[i*NW +: NW]  = NW'($urandom);
      end
      #1;
      last_gnt    = gnt1;
      last_rsp1   = rsp1;
      last_rsp3   = rsp3;
      last_busy1  = busy1;
      last_ms1    = ms1;
      last_start0 = req_start[PW-1:0];
      check_all();
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_gnt", gnt1, 0);
      chk("rst_rsp", rsp1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_gnt_l3", gnt3, 0);
      chk("rst_rsp_l3", rsp3, 0);
      chk("rst_busy_l3", busy3, 0);
      chk("rst_mem_start", ms1, 0);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic [N-1:0] rsp;
      logic         busy;
   } vec_t;

   vec_t         tbl [13];
   logic [N-1:0] obs  [270];
   logic [N-1:0] obs3 [16];
   logic [N-1:0] rq;
   int           bad;

   initial begin
      tbl = '{
         '{4'b0001, 4'b0000, 4'b0000, 1'b0},
         '{4'b0001, 4'b0001, 4'b0000, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0001, 4'b0001, 4'b0001, 1'b1},
         '{4'b0000, 4'b0001, 4'b0001, 1'b1},
         '{4'b0000, 4'b0000, 4'b0001, 1'b1},
         '{4'b0000, 4'b0000, 4'b0000, 1'b0}
      };
      model_reset();
      @(negedge clk);

      // Single requester held for ten cycles.
      do_reset();
      for (int j = 0; j < 13; j++) begin
         cycle(tbl[j].req);
         chk($sformatf("tbl%0d_gnt", j), last_gnt, tbl[j].gnt);
         chk($sformatf("tbl%0d_rsp", j), last_rsp1, tbl[j].rsp);
         chk($sformatf("tbl%0d_busy", j), last_busy1, tbl[j].busy);
         chk($sformatf("tbl%0d_mem", j), last_ms1, tbl[j].gnt[0] ? last_start0 : '0);
      end

      // All four requesting from reset: 0,1,2,3 with 64-cycle slices.
      do_reset();
      for (int j = 0; j < 262; j++) begin
         cycle(4'b1111);
         obs[j] = last_gnt;
      end
      chk("all_first_idle", obs[0], 0);
      for (int k = 0; k < 4; k++) begin
         bad = 0;
         for (int m = 0; m < Q; m++) begin
            if (obs[1 + 65*k + m] !== (N'(1) << k)) bad++;
         end
         chk($sformatf("slice%0d_bad_cycles", k), bad, 0);
         chk($sformatf("bubble%0d", k), obs[65*(k+1)], 0);
      end

      // Sole requester 2 saturated; requester 0 appears at cycle 150.
      do_reset();
      for (int j = 0; j < 160; j++) begin
         cycle(j >= 150 ? 4'b0101 : 4'b0100);
         obs[j] = last_gnt;
      end
      chk("sat_hold_149", obs[149], 4'b0100);
      chk("sat_hold_150", obs[150], 4'b0100);
      chk("sat_bubble_151", obs[151], 4'b0000);
      chk("sat_new_152", obs[152], 4'b0001);

      // Owner 1 releases exactly when its slice expires, 3 pending.
      do_reset();
      for (int j = 0; j < 70; j++) begin
         if (j < 10)      rq = 4'b0010;
         else if (j < 64) rq = 4'b1010;
         else             rq = 4'b1000;
         cycle(rq);
         obs[j] = last_gnt;
      end
      chk("rel_hold_64", obs[64], 4'b0010);
      chk("rel_gap_65", obs[65], 4'b0000);
      chk("rel_new_66", obs[66], 4'b1000);

      // Handover seen through the 3-cycle response pipe, then reset mid-burst.
      do_reset();
      for (int j = 0; j < 12; j++) begin
         cycle(j < 5 ? 4'b0011 : 4'b0010);
         obs[j]  = last_gnt;
         obs3[j] = last_rsp3;
      end
      chk("lat3_gnt7", obs[7], 4'b0010);
      chk("lat3_old_8", obs3[8], 4'b0001);
      chk("lat3_gap_9", obs3[9], 4'b0000);
      chk("lat3_new_10", obs3[10], 4'b0010);
      #1;
      chk("inflight_rsp3", rsp3, 4'b0010);
      do_reset();
      cycle(4'b0011);
      cycle(4'b0011);
      chk("restart_ptr0", last_gnt, 4'b0001);

      // Randomised sticky requests against the model.
      do_reset();
      rq = '0;
      for (int j = 0; j < 3000; j++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 99) < 1) rq[i] = ~rq[i];
         end
         cycle(rq);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
